// File: rtl/hist_train_mem.sv
// Histogram bin storage on the responder side of the hist_*_train bus.
// Zero-sweeps every bin after reset and on clr_start, returns registered read
// data one cycle after ren, and flags out-of-range addresses with a sticky bit.
module hist_train_mem #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] hist_addr_train,
  input  logic              hist_wen_train,
  input  logic [DATA_W-1:0] hist_wdata_train,
  input  logic              hist_ren_train,
  output logic [DATA_W-1:0] hist_rdata_train,
  output logic              hist_rvalid,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              addr_err,
  input  logic              err_clr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              ready;
  logic              last_ptr;
  logic              in_range;
  logic [PTR_W-1:0]  idx;

  assign ready    = (state == READY);
  assign last_ptr = (ptr == PTR_W'(DEPTH - 1));
  assign clr_busy = (state == CLEAR);

  // The whole address is compared (one extra bit so DEPTH == 2**ADDR_W still
  // works); only in-range addresses ever reach the array index.
  assign in_range = ({1'b0, hist_addr_train} < (ADDR_W + 1)'(DEPTH));
  assign idx      = hist_addr_train[PTR_W-1:0];

  // State register; reset always lands in CLEAR so the array gets swept.
  // NOTE: flops use non-blocking (<=) so every process sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAR;
    else        state <= state_nxt;
  end

  // Next state: sweep ends on the last bin; READY leaves on clr_start.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    state_nxt = state;
    unique case (state)
      CLEAR:   if (last_ptr)  state_nxt = READY;
      READY:   if (clr_start) state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  // Sweep pointer: walks 0..DEPTH-1 in CLEAR, parked at 0 otherwise so every
  // new sweep starts from bin 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          ptr <= '0;
    else if (!ready)     ptr <= last_ptr ? '0 : ptr + PTR_W'(1);
    else                 ptr <= '0;
  end

  // clr_done pulses in the first READY cycle after the final sweep write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clr_done <= 1'b0;
    else        clr_done <= !ready && last_ptr;
  end

  // Registered read port: old contents on a same-address write (read before
  // write), zero for out-of-range, holds its value when no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_rdata_train <= '0;
      hist_rvalid      <= 1'b0;
    end else begin
      hist_rvalid <= ready && hist_ren_train;
      if (ready && hist_ren_train)
        hist_rdata_train <= in_range ? mem[idx] : '0;
    end
  end

  // Sticky out-of-range flag; a new error in the same cycle beats err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      addr_err <= 1'b0;
    else if (ready && (hist_wen_train || hist_ren_train) && !in_range)
      addr_err <= 1'b1;
    else if (err_clr)
      addr_err <= 1'b0;
  end

  // Bin array: sweep writes zeros in CLEAR, bus writes land only in READY.
  // NOTE: the array has no reset; the CLEAR sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (!ready)
      mem[ptr] <= '0;
    else if (hist_wen_train && in_range)
      mem[idx] <= hist_wdata_train;
  end

endmodule

// File: tb/tb_hist_train_mem.sv
// Self-checking bench for hist_train_mem: a per-cycle behavioural model
// (countdown for the clear, plain array for the bins) compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_hist_train_mem;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] hist_addr_train = '0;
  logic              hist_wen_train = 1'b0;
  logic [DATA_W-1:0] hist_wdata_train = '0;
  logic              hist_ren_train = 1'b0;
  logic [DATA_W-1:0] hist_rdata_train;
  logic              hist_rvalid;
  logic              clr_start = 1'b0;
  logic              clr_busy;
  logic              clr_done;
  logic              addr_err;
  logic              err_clr = 1'b0;

  always #5 clk = ~clk;

  hist_train_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .hist_addr_train  (hist_addr_train),
    .hist_wen_train   (hist_wen_train),
    .hist_wdata_train (hist_wdata_train),
    .hist_ren_train   (hist_ren_train),
    .hist_rdata_train (hist_rdata_train),
    .hist_rvalid      (hist_rvalid),
    .clr_start        (clr_start),
    .clr_busy         (clr_busy),
    .clr_done         (clr_done),
    .addr_err         (addr_err),
    .err_clr          (err_clr)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          busy_left;            // clear cycles still to run
  logic [7:0]  m_mem [DEPTH];
  logic [7:0]  m_rdata;
  logic        m_rvalid, m_done, m_err;
  wire         m_bad = (hist_addr_train >= ADDR_W'(DEPTH));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_left <= DEPTH;
      m_rdata   <= '0;
      m_rvalid  <= 1'b0;
      m_done    <= 1'b0;
      m_err     <= 1'b0;
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
      m_rvalid  <= 1'b0;
      m_done    <= (busy_left == 1);
      if (busy_left == 1)
        foreach (m_mem[i]) m_mem[i] <= '0;
      if (err_clr) m_err <= 1'b0;
    end else begin
      m_done   <= 1'b0;
      m_rvalid <= hist_ren_train;
      if (hist_ren_train)
        m_rdata <= m_bad ? 8'h00 : m_mem[hist_addr_train];
      if (hist_wen_train && !m_bad)
        m_mem[hist_addr_train] <= hist_wdata_train;
      if ((hist_wen_train || hist_ren_train) && m_bad) m_err <= 1'b1;
      else if (err_clr)                                 m_err <= 1'b0;
      if (clr_start) busy_left <= DEPTH;
    end
  end

  // Compare process: every cycle outside reset, away from the rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("model_busy",   clr_busy,         busy_left > 0);
      check("model_rvalid", hist_rvalid,      m_rvalid);
      check("model_done",   clr_done,         m_done);
      check("model_err",    addr_err,         m_err);
      check("model_rdata",  hist_rdata_train, m_rdata);
    end
  end

  // ---------------- directed helpers (called at a falling edge) ----------------
  task automatic wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    hist_addr_train  = a;
    hist_wdata_train = d;
    hist_wen_train   = 1'b1;
    @(negedge clk);
    hist_wen_train   = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [7:0] exp, input string nm);
    hist_addr_train = a;
    hist_ren_train  = 1'b1;
    @(negedge clk);
    hist_ren_train  = 1'b0;
    check({nm, "_rvalid"}, hist_rvalid, 1'b1);
    check(nm, hist_rdata_train, exp);
  endtask

  // Counts busy samples until READY (bounded), then checks the done pulse.
  task automatic wait_clear(input string nm, input bit poke);
    int cnt = 0;
    while (clr_busy && cnt < 1000) begin
      cnt++;
      if (poke) begin
        hist_addr_train  = ADDR_W'($urandom_range(0, DEPTH - 1));
        hist_wdata_train = 8'($urandom);
        hist_wen_train   = 1'($urandom);
        hist_ren_train   = 1'($urandom);
        clr_start        = (cnt == 50);
      end
      @(negedge clk);
    end
    hist_wen_train = 1'b0;
    hist_ren_train = 1'b0;
    clr_start      = 1'b0;
    check({nm, "_busy_cycles"}, cnt, DEPTH);
    check({nm, "_done"}, clr_done, 1'b1);
    @(negedge clk);
    check({nm, "_done_pulse"}, clr_done, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_rdata",  hist_rdata_train, 8'h00);
    check("rst_rvalid", hist_rvalid,      1'b0);
    check("rst_done",   clr_done,         1'b0);
    check("rst_err",    addr_err,         1'b0);
    check("rst_busy",   clr_busy,         1'b1);
    rst_n = 1'b1;
    wait_clear("boot", 1'b0);

    // Fresh bins read zero, latency one.
    rd(21'd0,   8'h00, "boot_rd0");
    rd(21'd17,  8'h00, "boot_rd17");
    rd(21'd255, 8'h00, "boot_rd255");

    // Write then read.
    wr(21'd3, 8'h5A);
    rd(21'd3, 8'h5A, "wr_rd3");
    rd(21'd4, 8'h00, "rd4");

    // Same-cycle write and read: old value returned.
    wr(21'd10, 8'h07);
    hist_addr_train  = 21'd10;
    hist_wdata_train = 8'h08;
    hist_wen_train   = 1'b1;
    hist_ren_train   = 1'b1;
    @(negedge clk);
    hist_wen_train   = 1'b0;
    hist_ren_train   = 1'b0;
    check("rbw_old", hist_rdata_train, 8'h07);
    rd(21'd10, 8'h08, "rbw_new");

    // Out-of-range accesses and the sticky flag.
    wr(21'd0, 8'h33);
    wr(21'd256, 8'hFF);
    check("oor_wr_err", addr_err, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr", addr_err, 1'b0);
    rd(21'h1FFFFF, 8'h00, "oor_rd");
    check("oor_rd_err", addr_err, 1'b1);
    err_clr = 1'b1;
    rd(21'h100000, 8'h00, "oor_rd_clr");
    err_clr = 1'b0;
    check("set_wins", addr_err, 1'b1);
    rd(21'd0, 8'h33, "no_alias");

    // Randomised traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      hist_addr_train  = ($urandom_range(0, 9) == 0) ? ADDR_W'($urandom_range(DEPTH, 21'h1FFFFF))
                                                     : ADDR_W'($urandom_range(0, DEPTH - 1));
      hist_wdata_train = 8'($urandom);
      hist_wen_train   = 1'($urandom);
      hist_ren_train   = 1'($urandom);
      err_clr          = ($urandom_range(0, 15) == 0);
      clr_start        = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    hist_wen_train = 1'b0;
    hist_ren_train = 1'b0;
    err_clr        = 1'b0;
    clr_start      = 1'b0;
    while (clr_busy) @(negedge clk);  // bounded: a sweep is DEPTH cycles

    // Fill, clear with bus noise and a second clr_start mid-sweep.
    for (int i = 0; i < DEPTH; i++) wr(ADDR_W'(i), 8'h11);
    rd(21'd200, 8'h11, "fill_rd");
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    wait_clear("reclear", 1'b1);
    for (int i = 0; i < DEPTH; i++) rd(ADDR_W'(i), 8'h00, "after_clr");

    // Reset in the middle of a sweep.
    rd(21'h100000, 8'h00, "pre_rst_oor");
    wr(21'd5, 8'h77);
    rd(21'd5, 8'h77, "pre_rst_rd");
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_rdata", hist_rdata_train, 8'h00);
    check("midrst_err",   addr_err,         1'b0);
    check("midrst_busy",  clr_busy,         1'b1);
    check("midrst_done",  clr_done,         1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear("postrst", 1'b0);
    rd(21'd5, 8'h00, "postrst_rd5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
